// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: token, optional DATA0, then handshake or IN data + ACK.
// Define USB_TXN_RETRY_EN to retry failed attempts up to MAX_ATTEMPTS times in total.
module usb_txn_ctrl #(
    parameter int TIMEOUT_CYC  = 255,
    parameter int MAX_ATTEMPTS = 8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        req,
    input  logic        req_in,
    input  logic [6:0]  req_addr,
    input  logic [3:0]  req_endp,
    input  logic [63:0] req_data,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic        pkttype,
    output logic        pktready_bs,
    input  logic        down_ready,
    input  logic        sending_usb,
    output logic        writing,
    input  logic        in_pktready,
    input  logic [63:0] in_data,
    input  logic        in_error,
    input  logic        in_ack,
    input  logic        in_nak,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [63:0] rsp_data
);

    typedef enum logic [3:0] {
        IDLE, TOK, TOK_W, DAT, DAT_W, HS_WAIT, IN_WAIT, ACK_TX, ACK_W, FIN
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

    state_t     state;
    logic       is_in;
    logic       seen_send;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       attempt_fail;
    logic       send_done;

`ifdef USB_TXN_RETRY_EN
    logic [2:0] attempts;
    logic       retry_ok;
    assign retry_ok = (int'({29'd0, attempts}) + 1) < MAX_ATTEMPTS;
`endif

    assign tmo_hit      = (tmo_cnt == TMO_LIMIT);
    assign attempt_fail = ((state == HS_WAIT) || (state == IN_WAIT)) &&
                          (in_error || in_nak || tmo_hit);
    // A launched packet is finished once sending_usb has been seen high and is now low.
    assign send_done    = seen_send && !sending_usb;

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state       <= IDLE;
            is_in       <= 1'b0;
            seen_send   <= 1'b0;
            tmo_cnt     <= 8'd0;
            pid         <= 4'd0;
            addr        <= 7'd0;
            endp        <= 4'd0;
            data        <= 64'd0;
            pkttype     <= 1'b0;
            pktready_bs <= 1'b0;
            writing     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            success     <= 1'b0;
            rsp_data    <= 64'd0;
`ifdef USB_TXN_RETRY_EN
            attempts    <= 3'd0;
`endif
        end else begin
            pktready_bs <= 1'b0;
            done        <= 1'b0;
            if (sending_usb)
                seen_send <= 1'b1;

            if (attempt_fail) begin
`ifdef USB_TXN_RETRY_EN
                if (retry_ok) begin
                    attempts <= attempts + 3'd1;
                    state    <= TOK;
                    pid      <= is_in ? PID_IN : PID_OUT;
                    pkttype  <= 1'b0;
                    writing  <= 1'b1;
                end else begin
                    state   <= FIN;
                    done    <= 1'b1;
                    success <= 1'b0;
                end
`else
                state   <= FIN;
                done    <= 1'b1;
                success <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            is_in   <= req_in;
                            addr    <= req_addr;
                            endp    <= req_endp;
                            data    <= req_data;
                            pid     <= req_in ? PID_IN : PID_OUT;
                            pkttype <= 1'b0;
                            writing <= 1'b1;
                            busy    <= 1'b1;
                            success <= 1'b0;
                            state   <= TOK;
`ifdef USB_TXN_RETRY_EN
                            attempts <= 3'd0;
`endif
                        end
                    end
                    TOK, DAT, ACK_TX: begin
                        if (down_ready) begin
                            pktready_bs <= 1'b1;
                            seen_send   <= 1'b0;
                            state       <= (state == TOK) ? TOK_W :
                                           (state == DAT) ? DAT_W : ACK_W;
                        end
                    end
                    TOK_W: begin
                        if (send_done) begin
                            if (is_in) begin
                                state   <= IN_WAIT;
                                writing <= 1'b0;
                                tmo_cnt <= 8'd0;
                            end else begin
                                state   <= DAT;
                                pid     <= PID_DATA0;
                                pkttype <= 1'b1;
                            end
                        end
                    end
                    DAT_W: begin
                        if (send_done) begin
                            state   <= HS_WAIT;
                            writing <= 1'b0;
                            tmo_cnt <= 8'd0;
                        end
                    end
                    HS_WAIT: begin
                        if (in_ack) begin
                            state   <= FIN;
                            done    <= 1'b1;
                            success <= 1'b1;
                        end else if (tmo_cnt != 8'hFF) begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                    IN_WAIT: begin
                        if (in_pktready) begin
                            rsp_data <= in_data;
                            pid      <= PID_ACK;
                            pkttype  <= 1'b1;
                            writing  <= 1'b1;
                            state    <= ACK_TX;
                        end else if (tmo_cnt != 8'hFF) begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                    ACK_W: begin
                        if (send_done) begin
                            state   <= FIN;
                            writing <= 1'b0;
                            done    <= 1'b1;
                            success <= 1'b1;
                        end
                    end
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Self-checking bench for usb_txn_ctrl: directed scenarios plus randomized transactions
// checked against a packet-list reference model; honours USB_TXN_RETRY_EN.
module tb_usb_txn_ctrl;

    localparam int TIMEOUT_CYC  = 255;
    localparam int MAX_ATTEMPTS = 8;
`ifdef USB_TXN_RETRY_EN
    localparam int ATTEMPTS_ALLOWED = MAX_ATTEMPTS;
`else
    localparam int ATTEMPTS_ALLOWED = 1;
`endif

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;

    typedef enum int {R_GOOD, R_NAK, R_ERR, R_NONE} rsp_kind_t;
    typedef struct packed {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
        logic        pkttype;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_L, req, req_in, down_ready;
    logic        sending_usb = 1'b0;
    logic [6:0]  req_addr;
    logic [3:0]  req_endp;
    logic [63:0] req_data, in_data;
    logic        in_pktready, in_error, in_ack, in_nak;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data, rsp_data;
    logic        pkttype, pktready_bs, writing, busy, done, success;

    int          checks = 0;
    int          errors = 0;
    pkt_t        seen_q[$];
    pkt_t        exp_q[$];
    pkt_t        cap;
    logic [63:0] rsp_model = 64'd0;
    rsp_kind_t   plan_a[8];
    int          dly_a[8];
    int          hold_ready = 0;
    bit          poke_busy = 1'b0;
    bit          release_reset = 1'b0;
    bit          pipe_abort = 1'b0;
    bit          pipe_busy = 1'b0;

    usb_txn_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_ATTEMPTS(MAX_ATTEMPTS)) dut (
        .clk(clk), .rst_L(rst_L), .req(req), .req_in(req_in), .req_addr(req_addr),
        .req_endp(req_endp), .req_data(req_data), .pid(pid), .addr(addr), .endp(endp),
        .data(data), .pkttype(pkttype), .pktready_bs(pktready_bs), .down_ready(down_ready),
        .sending_usb(sending_usb), .writing(writing), .in_pktready(in_pktready),
        .in_data(in_data), .in_error(in_error), .in_ack(in_ack), .in_nak(in_nak),
        .busy(busy), .done(done), .success(success), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic pkt_t mk_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                                    input logic [63:0] d, input logic t);
        mk_pkt = '{pid: p, addr: a, endp: e, data: d, pkttype: t};
    endfunction

    // Transmit pipeline model: records each launched packet, then plays it out on sending_usb.
    always begin
        @(negedge clk);
        if (rst_L && pktready_bs) begin
            pipe_busy = 1'b1;
            cap = '{pid: pid, addr: addr, endp: endp, data: data, pkttype: pkttype};
            seen_q.push_back(cap);
            checkOutput("writing_at_launch", 64'(writing), 64'd1);
            @(negedge clk);
            checkOutput("pktready_one_cycle", 64'(pktready_bs), 64'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sending_usb = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                if (!pipe_abort) begin
                    checkOutput("fields_stable", 64'({pid, addr, endp, pkttype}),
                                64'({cap.pid, cap.addr, cap.endp, cap.pkttype}));
                    checkOutput("data_stable", data, cap.data);
                end
            end
            sending_usb = 1'b0;
            pipe_busy = 1'b0;
        end
    end

    task automatic check_all_zero(input string phase);
        checkOutput({phase, "_pktready"}, 64'(pktready_bs), 64'd0);
        checkOutput({phase, "_writing"}, 64'(writing), 64'd0);
        checkOutput({phase, "_busy"}, 64'(busy), 64'd0);
        checkOutput({phase, "_done"}, 64'(done), 64'd0);
        checkOutput({phase, "_success"}, 64'(success), 64'd0);
        checkOutput({phase, "_fields"}, 64'({pid, addr, endp, pkttype}), 64'd0);
        checkOutput({phase, "_data"}, data, 64'd0);
        checkOutput({phase, "_rsp_data"}, rsp_data, 64'd0);
    endtask

    task automatic wait_writing(input logic level, input string tag);
        int n = 0;
        while (writing !== level && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(writing), 64'(level));
    endtask

    task automatic set_plan(input rsp_kind_t k, input int d);
        for (int a = 0; a < 8; a++) begin
            plan_a[a] = k;
            dly_a[a]  = d;
        end
    endtask

    task automatic applyStimulus(input logic t_in, input logic [6:0] t_addr, input logic [3:0] t_endp,
                                 input logic [63:0] t_data, input logic [63:0] t_rsp);
        int n_att = 0;
        bit ok = 1'b0;
        int cnt;
        int early;
        // Expected behaviour: each attempt sends a token (plus DATA0 for OUT); the first good
        // response ends the transaction, IN successes additionally send an ACK.
        exp_q.delete();
        for (int a = 0; a < ATTEMPTS_ALLOWED; a++) begin
            n_att++;
            exp_q.push_back(mk_pkt(t_in ? PID_IN : PID_OUT, t_addr, t_endp, 64'd0, 1'b0));
            if (!t_in) exp_q.push_back(mk_pkt(PID_DATA0, t_addr, t_endp, t_data, 1'b1));
            if (plan_a[a] == R_GOOD) begin
                if (t_in) exp_q.push_back(mk_pkt(PID_ACK, t_addr, t_endp, 64'd0, 1'b1));
                ok = 1'b1;
                break;
            end
        end
        if (ok && t_in) rsp_model = t_rsp;
        seen_q.delete();

        if (hold_ready > 0) down_ready = 1'b0;
        req = 1'b1; req_in = t_in; req_addr = t_addr; req_endp = t_endp; req_data = t_data;
        if (release_reset) rst_L = 1'b1;
        release_reset = 1'b0;
        @(negedge clk);
        req = 1'b0; req_in = ~t_in; req_addr = 7'($urandom); req_endp = 4'($urandom);
        req_data = {$urandom, $urandom};
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        if (hold_ready > 0) begin
            early = 0;
            repeat (hold_ready) begin
                @(negedge clk);
                if (pktready_bs) early++;
            end
            checkOutput("launch_held_while_not_ready", 64'(early), 64'd0);
            down_ready = 1'b1;
            hold_ready = 0;
        end

        for (int a = 0; a < n_att; a++) begin
            wait_writing(1'b1, "writing_rise");
            wait_writing(1'b0, "writing_fall");
            if (plan_a[a] == R_NONE) begin
                cnt = 0;
                while (!writing && !done && cnt < TIMEOUT_CYC + 50) begin
                    @(negedge clk);
                    cnt++;
                end
                checkOutput("timeout_cycles", 64'(cnt), 64'(TIMEOUT_CYC + 1));
            end else begin
                if (poke_busy) begin
                    req = 1'b1; req_addr = 7'($urandom);
                    @(negedge clk);
                    req = 1'b0;
                end
                repeat (dly_a[a]) @(negedge clk);
                in_data = t_rsp;
                case (plan_a[a])
                    R_GOOD: if (t_in) in_pktready = 1'b1; else in_ack = 1'b1;
                    R_NAK: begin
                        in_nak = 1'b1;
                        in_ack = 1'($urandom_range(0, 1));
                        in_pktready = 1'($urandom_range(0, 1));
                    end
                    default: begin
                        in_error = 1'b1;
                        in_nak = 1'($urandom_range(0, 1));
                        in_ack = 1'($urandom_range(0, 1));
                        in_pktready = 1'($urandom_range(0, 1));
                    end
                endcase
                @(negedge clk);
                in_pktready = 1'b0; in_ack = 1'b0; in_nak = 1'b0; in_error = 1'b0;
                in_data = {$urandom, $urandom};
            end
        end

        cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("success", 64'(success), 64'(ok));
        checkOutput("rsp_data", rsp_data, rsp_model);
        checkOutput("busy_in_fin", 64'(busy), 64'd1);
        checkOutput("writing_in_fin", 64'(writing), 64'd0);
        checkOutput("pkt_count", 64'(seen_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            checkOutput("pkt_pid", 64'(seen_q[i].pid), 64'(exp_q[i].pid));
            checkOutput("pkt_type", 64'(seen_q[i].pkttype), 64'(exp_q[i].pkttype));
            if (!exp_q[i].pkttype)
                checkOutput("pkt_addr_endp", 64'({seen_q[i].addr, seen_q[i].endp}),
                            64'({exp_q[i].addr, exp_q[i].endp}));
            if (exp_q[i].pid == PID_DATA0)
                checkOutput("pkt_data", seen_q[i].data, exp_q[i].data);
        end
        @(negedge clk);
        checkOutput("done_cleared", 64'(done), 64'd0);
        checkOutput("busy_cleared", 64'(busy), 64'd0);
        checkOutput("success_held", 64'(success), 64'(ok));
    endtask

    initial begin
        int cnt;
        int r;
        rst_L = 1'b0; req = 1'b0; req_in = 1'b0; req_addr = 7'd0; req_endp = 4'd0;
        req_data = 64'd0; down_ready = 1'b1; in_data = 64'd0;
        in_pktready = 1'b0; in_error = 1'b0; in_ack = 1'b0; in_nak = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        $display("[TB] OUT transaction accepted on first edge out of reset");
        set_plan(R_GOOD, 20);
        release_reset = 1'b1;
        applyStimulus(1'b0, 7'h05, 4'h2, 64'hDEADBEEF_CAFEF00D, 64'd0);

        $display("[TB] IN transaction with data response");
        set_plan(R_GOOD, 7);
        applyStimulus(1'b1, 7'h11, 4'h3, 64'd0, 64'h0123456789ABCDEF);

        $display("[TB] OUT transaction with no response");
        set_plan(R_NONE, 0);
        applyStimulus(1'b0, 7'h22, 4'h1, 64'h1111_2222_3333_4444, 64'd0);

        $display("[TB] OUT transaction NAKed twice then ACKed");
        set_plan(R_GOOD, 3);
        plan_a[0] = R_NAK;
        plan_a[1] = R_NAK;
        applyStimulus(1'b0, 7'h33, 4'h4, 64'h5555_6666_7777_8888, 64'd0);

        $display("[TB] reset asserted while the DATA0 packet is on the bus");
        req = 1'b1; req_in = 1'b0; req_addr = 7'h44; req_endp = 4'h5; req_data = 64'hA5A5;
        @(negedge clk);
        req = 1'b0;
        cnt = 0;
        while (seen_q.size() < 2 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("reached_dat_w", 64'(seen_q.size()), 64'd2);
        pipe_abort = 1'b1;
        rst_L = 1'b0;
        @(negedge clk);
        check_all_zero("mid_packet_reset");
        rsp_model = 64'd0;
        rst_L = 1'b1;
        cnt = 0;
        while (pipe_busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        seen_q.delete();
        pipe_abort = 1'b0;
        set_plan(R_GOOD, 2);
        applyStimulus(1'b1, 7'h45, 4'h6, 64'd0, 64'hFEDC_BA98_7654_3210);

        $display("[TB] down_ready held low for 50 cycles, request pulsed while busy");
        set_plan(R_GOOD, 4);
        hold_ready = 50;
        poke_busy = 1'b1;
        applyStimulus(1'b0, 7'h7F, 4'hF, 64'hFFFF_0000_FFFF_0000, 64'd0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 12; t++) begin
            for (int a = 0; a < 8; a++) begin
                r = $urandom_range(0, 15);
                plan_a[a] = (r < 1) ? R_NONE : (r < 4) ? R_NAK : (r < 7) ? R_ERR : R_GOOD;
                dly_a[a]  = $urandom_range(0, 30);
            end
            poke_busy = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
